uart_cmd_rx: RTL
================

Name: uart_cmd_rx

Overview:
- Consumer on the receive side of the usb_uart byte pipeline: accepts the host→device stream (uart_out_data/valid/ready) and parses line-oriented ASCII hex commands.
- Produces single-cycle register write/read strobes.
- Counterpart to the transmit-side string generator: lets the host poke internal registers over the same USB serial link.

Parameters:
- TIMEOUT_CYCLES, 48000000, clk_48mhz cycles of input silence that abort a partial command; 0 disables the timeout.
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk_48mhz  in  1  system clock, 48 MHz from PLL
- reset  in  1  synchronous, active-high reset
- in_data  in  8  received byte; connects to usb_uart.uart_out_data
- in_valid  in  1  byte valid; connects to uart_out_valid
- in_ready  out  1  byte accepted when in_valid & in_ready; connects to uart_out_ready
- wr_en  out  1  one-cycle register write strobe
- rd_en  out  1  one-cycle register read strobe
- addr  out  8  register address; valid while wr_en or rd_en is high; holds value otherwise
- wr_data  out  8  write data; valid with wr_en
- cmd_err  out  1  one-cycle pulse per rejected command line
- err_count  out  ERR_CNT_W  count of rejected lines, saturating at all-ones
- busy  out  1  high when state != IDLE

Behaviour:
- Grammar, hex case-insensitive ('0'-'9', 'a'-'f', 'A'-'F'); terminator is CR (0x0D) or LF (0x0A):
  - write: 'W'|'w' A1 A0 D1 D0 terminator
  - read: 'R'|'r' A1 A0 terminator
- Byte transfer only on in_valid & in_ready. in_ready=1 in every state except EXEC and except during reset.
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, EOL, EXEC, ERR.
- IDLE:
  - CR, LF, space (0x20) ignored.
  - 'W' -> ADDR_HI with is_wr=1; 'R' -> ADDR_HI with is_wr=0.
  - Any other byte -> ERR.
- ADDR_HI/ADDR_LO: hex digit shifts into addr_sh (high nibble first).
- After ADDR_LO: -> DATA_HI if is_wr, else -> EOL.
- DATA_HI/DATA_LO: hex digit shifts into data_sh; after DATA_LO -> EOL.
- EOL: terminator -> EXEC.
- Error paths:
  - Non-hex byte in ADDR_*/DATA_*, or non-terminator in EOL -> ERR.
  - Terminator in ADDR_*/DATA_* (short command) -> pulse cmd_err next cycle, then IDLE; does not pass through ERR.
- ERR: discard bytes until a terminator; on terminator pulse cmd_err for one cycle and -> IDLE.
- EXEC: lasts exactly one cycle.
  - wr_en=is_wr, rd_en=!is_wr, addr=addr_sh, wr_data=data_sh (write only).
  - Then -> IDLE.
- Latency: terminator accepted at cycle N -> strobe high at N+1, in_ready low at N+1, IDLE (in_ready=1) at N+2.
- cmd_err: pulses at the cycle after the terminator that closes a bad line. err_count increments in that same cycle; it holds at all-ones rather than wrapping.
- Timeout:
  - Counter clears on every accepted byte and in IDLE; increments otherwise in ADDR_*/DATA_*/EOL/ERR.
  - Reaching TIMEOUT_CYCLES -> IDLE, cmd_err pulse, err_count++.
  - A byte accepted in the same cycle the timeout expires wins: the byte is processed and the counter clears.
- Reset, any cycle including mid-command:
  - State -> IDLE, partial command discarded.
  - wr_en=rd_en=cmd_err=0, addr=0, wr_data=0, err_count=0, busy=0, in_ready=0 while reset is high.
- Strobes never overlap. A new command cannot complete until 2 cycles after the previous terminator.

Decomposition:
- Package uart_cmd_pkg:
  - state enum
  - ASCII constants (CR, LF, SPACE, 'W', 'w', 'R', 'r')
  - function returning {is_hex, nibble[3:0]} from a byte
- Optional sub-module ascii_hex_decode (purely combinational: byte -> valid, nibble), instantiated once.
- FSM, shift registers, timeout counter and error counter stay in uart_cmd_rx.

Test Plan:
- "W3Ca5\r" back-to-back valid -> one cycle after '\r' accepted: wr_en=1, addr=0x3C, wr_data=0xA5; in_ready=0 that cycle; no cmd_err.
- "r7F\n" with in_valid toggling every other cycle -> rd_en=1 once, addr=0x7F, wr_en never high.
- "W1G00\r" -> no strobe; cmd_err exactly one pulse after '\r'; err_count 0->1. A following "R01\r" then gives rd_en with addr=0x01.
- Timeout: with TIMEOUT_CYCLES=100, send "W12" then idle -> cmd_err pulse at 100 cycles after the '2'; busy drops. Repeat with a byte arriving exactly at cycle 100 -> no timeout.
- Error saturation: ERR_CNT_W=2, send "X\r" five times -> err_count sequence 1,2,3,3,3.
- Reset asserted after "W12" -> no strobes. After reset releases, "W1234\r" -> wr_en with addr=0x12, wr_data=0x34. Also "\r\n \r" in IDLE -> no cmd_err.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command parser.
// State encoding, ASCII constants and a hex-digit classifier.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_EOL,
    S_EXEC,
    S_ERR
  } state_t;

  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_WU = 8'h57;
  localparam logic [7:0] CH_WL = 8'h77;
  localparam logic [7:0] CH_RU = 8'h52;
  localparam logic [7:0] CH_RL = 8'h72;

  // Returns {is_hex, nibble}; letters map via low nibble + 9.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder.
// Ports: ch (byte in), valid (is hex digit), nibble (value).
module ascii_hex_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid,
  output logic [3:0] nibble
);

  assign {valid, nibble} = hex_nib(ch);

endmodule

// File: rtl/uart_cmd_rx.sv
// Line-oriented ASCII hex command parser (W aadd / R aa).
// Ports: byte stream in (valid/ready), wr/rd strobes, cmd_err, err_count.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48000000,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [7:0]           addr,
  output logic [7:0]           wr_data,
  output logic                 cmd_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_ON = (TIMEOUT_CYCLES != 0);

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_sh_q, addr_sh_d;
  logic [7:0]    data_sh_q, data_sh_d;
  logic [TW-1:0] tmo_q;
  logic          err_set;
  logic          is_hex;
  logic [3:0]    nib;

  ascii_hex_decode u_hex (
    .ch     (in_data),
    .valid  (is_hex),
    .nibble (nib)
  );

  wire acc     = in_valid & in_ready;
  wire is_term = (in_data == CH_CR) || (in_data == CH_LF);
  wire is_w    = (in_data == CH_WU) || (in_data == CH_WL);
  wire is_r    = (in_data == CH_RU) || (in_data == CH_RL);
  wire is_sp   = (in_data == CH_SP);

  // Silence is only timed while a line is open.
  wire counting = (state_q != S_IDLE) &&
                  (state_q != S_EXEC);
  // An accepted byte beats an expiring timer.
  wire tmo_hit  = TMO_ON && counting && !acc &&
                  (tmo_q == TMO_LAST);

  assign in_ready = !reset && (state_q != S_EXEC);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    err_set   = 1'b0;
    if (tmo_hit) begin
      state_d = S_IDLE;
      err_set = 1'b1;
    end else if (state_q == S_EXEC) begin
      state_d = S_IDLE;
    end else if (acc) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            is_w: begin
              state_d = S_ADDR_HI;
              is_wr_d = 1'b1;
            end
            is_r: begin
              state_d = S_ADDR_HI;
              is_wr_d = 1'b0;
            end
            (is_term || is_sp): ;
            default: state_d = S_ERR;
          endcase
        end
        S_ADDR_HI, S_ADDR_LO: begin
          if (is_hex) begin
            addr_sh_d = {addr_sh_q[3:0], nib};
            if (state_q == S_ADDR_HI)
              state_d = S_ADDR_LO;
            else
              state_d = is_wr_q ? S_DATA_HI : S_EOL;
          end else if (is_term) begin
            // Short line: report without detouring via ERR.
            state_d = S_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_DATA_HI, S_DATA_LO: begin
          if (is_hex) begin
            data_sh_d = {data_sh_q[3:0], nib};
            state_d   = (state_q == S_DATA_HI) ?
                        S_DATA_LO : S_EOL;
          end else if (is_term) begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_EOL:
          state_d = is_term ? S_EXEC : S_ERR;
        S_ERR: begin
          if (is_term) begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      if (acc || !counting || tmo_hit || !TMO_ON)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;
    end
  end

  // Strobes register the EXEC entry so they line up with it.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      cmd_err   <= 1'b0;
      err_count <= '0;
    end else begin
      wr_en   <= (state_d == S_EXEC) && is_wr_q;
      rd_en   <= (state_d == S_EXEC) && !is_wr_q;
      cmd_err <= err_set;
      if (state_d == S_EXEC) begin
        addr <= addr_sh_q;
        if (is_wr_q)
          wr_data <= data_sh_q;
      end
      if (err_set && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule
